nbit_adder_reg: RTL and testbench
=================================

Name: nbit_adder_reg

Overview:
- Parameterised N-bit binary adder with carry-in and carry-out, built as a ripple chain of 1-bit full-adder cells.
- Operands are captured combinationally and the result is registered, giving one clock of latency.
- Used as the adder datapath slice inside the ALU. Sum and carry feed the ALU result mux and flag logic.

Parameters:
- N, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b/c_in are valid this cycle.
- a  input  N  operand A, unsigned (or two's complement; the bit pattern is identical).
- b  input  N  operand B.
- c_in  input  1  carry into bit 0.
- sum  output  N  registered a + b + c_in, low N bits.
- c_out  output  1  registered carry out of bit N-1.
- out_valid  output  1  sum/c_out hold the result of a valid operation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, sum=0, c_out=0, out_valid=0, forced immediately without waiting for a clock edge.
- Release: reset deasserts synchronously to clk, and the first capture happens at the first rising edge with rst_n=1.
- Combinational core: {c_out_next, sum_next} = a + b + c_in, computed as an (N+1)-bit result with zero-extended operands.
- Carry chain: ripple through N full-adder cells; cell i takes a[i], b[i], carry[i]; carry[0]=c_in; c_out_next=carry[N].
- Capture with in_valid=1: sum<=sum_next, c_out<=c_out_next, out_valid<=1.
- No capture with in_valid=0: sum and c_out hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle from in_valid to out_valid. Throughput is 1 operation per cycle.
- No backpressure: no ready signal; a result is valid only in the cycle out_valid=1.
- Wrap-around: all-ones + 1 (or all-ones + 0 + c_in=1) gives sum=0, c_out=1.
- Maximum case: all-ones + all-ones + 1 gives sum=all-ones, c_out=1.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 on the next cycle after release unless in_valid=1 at that edge.
- No X propagation: inputs are sampled only when in_valid=1. Held outputs never change while in_valid=0.

Optional Feature:
- Macro: NBIT_ADDER_FLAGS_EN.
- When defined, three extra outputs are added, all registered together with sum and reset to 0. All three update only on capture.
  - overflow (1 bit): signed overflow, carry[N] XOR carry[N-1].
  - zero (1 bit): sum_next == 0.
  - negative (1 bit): sum_next[N-1].
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - localparam ADDER_MAX_N = 64.
  - typedef struct flags_t {overflow, zero, negative} for ALU flag buses.
- Sub-module full_adder_cell (a, b, cin -> s, cout; s = a^b^cin, cout = ab | cin(a^b)), instantiated N times in a generate loop.
- The top module holds only the chain wiring, the output registers and the optional flag logic.

Test Plan (N=4):
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> sum=0, c_out=0, out_valid=0 at all times, including mid-cycle assertion.
- Basic add: a=3, b=4, c_in=0, in_valid=1 -> next cycle sum=7, c_out=0, out_valid=1.
- Wrap: a=4'hF, b=1, c_in=0 -> sum=0, c_out=1. Then a=4'hF, b=4'hF, c_in=1 -> sum=4'hF, c_out=1.
- Exhaustive sweep: increment {c_in,a,b} from 0 every cycle with in_valid=1 over all 512 combinations -> each result matches a+b+c_in one cycle later.
- Hold: in_valid=0 while inputs change -> sum and c_out keep their last values; out_valid=0.
- Flags (macro on): a=7, b=1 -> sum=8, overflow=1, negative=1, zero=0. a=8, b=8 -> sum=0, c_out=1, overflow=1, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types and limits used by the adder slice and the flag logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int ADDER_MAX_N = 64;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage : alu_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder cell, the repeated element of the ripple carry chain.
// Latency: purely combinational.
// Backpressure: not applicable.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : full_adder_cell

// File: rtl/nbit_adder_reg.sv
// N-bit ripple-carry adder with registered sum/carry; optional flags via NBIT_ADDER_FLAGS_EN.
// Latency: 1 clock from in_valid to out_valid, one operation per cycle.
// Backpressure: none; a result is only valid in the cycle out_valid is high.
module nbit_adder_reg
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         out_valid
`ifdef NBIT_ADDER_FLAGS_EN
    ,
    output logic         overflow,
    output logic         zero,
    output logic         negative
`endif
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_sum_next;

    logic [N-1:0] r_sum;
    logic         r_c_out;
    logic         r_out_valid;

    assign w_carry[0] = c_in;

    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        full_adder_cell u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (w_carry[gi]),
            .s    (w_sum_next[gi]),
            .cout (w_carry[gi+1])
        );
    end

    // Outputs hold while in_valid is low, so unsampled inputs never reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum_next;
                r_c_out <= w_carry[N];
            end
        end
    end

    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign out_valid = r_out_valid;

`ifdef NBIT_ADDER_FLAGS_EN
    flags_t w_flags_next;
    flags_t r_flags;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign w_flags_next.overflow = w_carry[N] ^ w_carry[N-1];
    assign w_flags_next.zero     = (w_sum_next == '0);
    assign w_flags_next.negative = w_sum_next[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (in_valid) begin
            r_flags <= w_flags_next;
        end
    end

    assign overflow = r_flags.overflow;
    assign zero     = r_flags.zero;
    assign negative = r_flags.negative;
`endif

endmodule : nbit_adder_reg

// File: tb/tb_nbit_adder_reg.sv
// Directed self-checking bench for nbit_adder_reg at N=4.
// Flag checks are compiled in only when NBIT_ADDER_FLAGS_EN is defined.
module tb_nbit_adder_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       out_valid;
`ifdef NBIT_ADDER_FLAGS_EN
    logic       overflow;
    logic       zero;
    logic       negative;
`endif

    int n_cmp;
    int n_err;

    nbit_adder_reg #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
`ifdef NBIT_ADDER_FLAGS_EN
        ,
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_sum, input logic e_c, input logic e_v);
        chk({tag, ".sum"},       {28'd0, sum},       {28'd0, e_sum});
        chk({tag, ".c_out"},     {31'd0, c_out},     {31'd0, e_c});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_v});
    endtask

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb;
        c_in     = tc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] vec;
        logic [4:0] exp5;
        n_cmp = 0;
        n_err = 0;

        // Reset held with random valid inputs: outputs must stay cleared.
        rst_n = 1'b0;
        drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        #1;
        chk_out("reset_t0", 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
            chk_out($sformatf("reset_hold%0d", i), 4'h0, 1'b0, 1'b0);
        end

        // Release with in_valid low: no result on first edge.
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("release_idle", 4'h0, 1'b0, 1'b0);

        // Basic add
        drive(1'b1, 4'd3, 4'd4, 1'b0);
        step();
        chk_out("add_3_4", 4'd7, 1'b0, 1'b1);

        // Wrap and maximum cases
        drive(1'b1, 4'hF, 4'h1, 1'b0);
        step();
        chk_out("wrap_F_1", 4'h0, 1'b1, 1'b1);
        drive(1'b1, 4'hF, 4'h0, 1'b1);
        step();
        chk_out("wrap_F_0_c", 4'h0, 1'b1, 1'b1);
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        step();
        chk_out("max_F_F_c", 4'hF, 1'b1, 1'b1);

        // Mid-cycle asynchronous reset clears a valid result at once.
        drive(1'b1, 4'd5, 4'd6, 1'b0);
        step();
        chk_out("pre_mid_reset", 4'd11, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 4'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd1, 4'd1, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("post_reset_idle", 4'h0, 1'b0, 1'b0);

        // Exhaustive sweep over {c_in, a, b}
        for (int i = 0; i < 512; i++) begin
            vec = 9'(i);
            drive(1'b1, vec[7:4], vec[3:0], vec[8]);
            exp5 = {1'b0, vec[7:4]} + {1'b0, vec[3:0]} + {4'd0, vec[8]};
            step();
            chk_out($sformatf("sweep%0d", i), exp5[3:0], exp5[4], 1'b1);
        end

        // Hold: last sweep result was F+F+1 = 0x1F.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'(i + 2), 4'(i * 3), 1'(i));
            step();
            chk_out($sformatf("hold%0d", i), 4'hF, 1'b1, 1'b0);
        end

`ifdef NBIT_ADDER_FLAGS_EN
        drive(1'b1, 4'd7, 4'd1, 1'b0);
        step();
        chk_out("flag_7_1", 4'd8, 1'b0, 1'b1);
        chk("flag_7_1.overflow", {31'd0, overflow}, 32'd1);
        chk("flag_7_1.negative", {31'd0, negative}, 32'd1);
        chk("flag_7_1.zero",     {31'd0, zero},     32'd0);
        drive(1'b1, 4'd8, 4'd8, 1'b0);
        step();
        chk_out("flag_8_8", 4'd0, 1'b1, 1'b1);
        chk("flag_8_8.overflow", {31'd0, overflow}, 32'd1);
        chk("flag_8_8.zero",     {31'd0, zero},     32'd1);
        chk("flag_8_8.negative", {31'd0, negative}, 32'd0);
        drive(1'b0, 4'd1, 4'd2, 1'b0);
        step();
        chk("flag_hold.zero",     {31'd0, zero},     32'd1);
        chk("flag_hold.overflow", {31'd0, overflow}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nbit_adder_reg
